// File: rtl/burst_channel_pkg.sv
// burst_channel_pkg
// Shared definitions for the burst error channel: the two-state burst FSM
// encoding, the xorshift32 shift amounts and a helper that computes the next
// generator value. No ports; imported by xorshift32_rng and
// burst_error_channel.
package burst_channel_pkg;

  // NORMAL waits for a first error; PROP models DFE error propagation.
  typedef enum logic {
    NORMAL = 1'b0,
    PROP   = 1'b1
  } burst_state_e;

  localparam int unsigned XS_SHIFT_A = 13;
  localparam int unsigned XS_SHIFT_B = 17;
  localparam int unsigned XS_SHIFT_C = 5;

  // One xorshift32 step. A non-zero input never produces zero.
  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << XS_SHIFT_A);
    y = y ^ (y >> XS_SHIFT_B);
    y = y ^ (y << XS_SHIFT_C);
    return y;
  endfunction

endpackage

// File: rtl/xorshift32_rng.sv
// xorshift32_rng
// Holds the xorshift32 generator state used for every error decision.
// Ports:
//   clk     - clock, all logic on posedge
//   rst     - synchronous active-high reset, reloads SEED
//   advance - step the generator once on this edge
//   rnd     - current generator value (the value before this edge's step)
// Parameter SEED must be non-zero, otherwise the generator sticks at zero.
module xorshift32_rng
  import burst_channel_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] rnd
);

  logic [31:0] rnd_q;
  logic [31:0] rnd_d;

  // The generator only moves when a valid bit is consumed, so the decision
  // sequence depends solely on how many valid bits have been seen.
  always_comb begin
    rnd_d = rnd_q;
    if (advance) begin
      rnd_d = xorshift32_next(rnd_q);
    end
  end

  // State register; reset reloads the seed so flip positions replay exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q <= SEED;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  assign rnd = rnd_q;

endmodule

// File: rtl/burst_error_channel.sv
// burst_error_channel
// Bit-serial channel model: flips bits of a valid-qualified serial stream
// using a two-state burst model (random first error, then propagation) and
// counts flipped bits and started bursts.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   data_in         - serial bit from the pattern generator
//   data_in_valid   - data_in qualifier; idle cycles change no state
//   inject_en       - low passes bits unmodified and forces NORMAL
//   p_err           - threshold for starting a burst (hit = rnd < p_err)
//   p_prop          - threshold for continuing a burst (hit = rnd < p_prop)
//   data_out        - registered data_in XOR flip, held while not valid
//   data_out_valid  - registered data_in_valid
//   error_flag      - high with data_out_valid when that bit was flipped
//   total_injected  - count of flipped bits, wraps
//   total_bursts    - count of bursts started, wraps
module burst_error_channel
  import burst_channel_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int          MAX_BURST = 16,
  parameter int          CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_in_valid,
  input  logic             inject_en,
  input  logic [31:0]      p_err,
  input  logic [31:0]      p_prop,
  output logic             data_out,
  output logic             data_out_valid,
  output logic             error_flag,
  output logic [CNT_W-1:0] total_injected,
  output logic [CNT_W-1:0] total_bursts
);

  localparam logic [7:0] MAX_BURST_L = 8'(MAX_BURST);

  logic [31:0]      rnd;
  burst_state_e     state_q, state_d;
  logic [7:0]       burst_len_q, burst_len_d;
  logic             data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] injected_q, injected_d;
  logic [CNT_W-1:0] bursts_q, bursts_d;
  logic             flip;

  xorshift32_rng #(
    .SEED (SEED)
  ) u_rng (
    .clk     (clk),
    .rst     (rst),
    .advance (data_in_valid),
    .rnd     (rnd)
  );

  // Burst FSM, flip decision and output/counter next values. Every decision
  // uses the generator value from before this edge's step. Idle cycles keep
  // all state; data_out holds and error_flag drops.
  always_comb begin
    state_d     = state_q;
    burst_len_d = burst_len_q;
    flip        = 1'b0;
    bursts_d    = bursts_q;

    if (data_in_valid) begin
      if (!inject_en) begin
        state_d     = NORMAL;
        burst_len_d = 8'd0;
      end else begin
        unique case (state_q)
          NORMAL: begin
            if (rnd < p_err) begin
              flip        = 1'b1;
              state_d     = PROP;
              burst_len_d = 8'd1;
              bursts_d    = bursts_q + CNT_W'(1);
            end
          end
          PROP: begin
            // A bit that ends a burst is never tested against p_err.
            if ((burst_len_q < MAX_BURST_L) && (rnd < p_prop)) begin
              flip        = 1'b1;
              burst_len_d = burst_len_q + 8'd1;
            end else begin
              state_d     = NORMAL;
              burst_len_d = 8'd0;
            end
          end
          default: begin
            state_d     = NORMAL;
            burst_len_d = 8'd0;
          end
        endcase
      end
    end

    valid_d    = data_in_valid;
    error_d    = data_in_valid & flip;
    data_out_d = data_in_valid ? (data_in ^ flip) : data_out_q;
    injected_d = flip ? (injected_q + CNT_W'(1)) : injected_q;
  end

  // Registers; reset aborts any burst in progress and clears statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NORMAL;
      burst_len_q <= 8'd0;
      data_out_q  <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      injected_q  <= '0;
      bursts_q    <= '0;
    end else begin
      state_q     <= state_d;
      burst_len_q <= burst_len_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      injected_q  <= injected_d;
      bursts_q    <= bursts_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign error_flag     = error_q;
  assign total_injected = injected_q;
  assign total_bursts   = bursts_q;

endmodule

// File: tb/tb_burst_error_channel.sv
// tb_burst_error_channel
// Randomized self-checking bench for burst_error_channel. A behavioural model
// tracks the xorshift sequence and the burst rules bit by bit and predicts
// every registered output and counter value.
module tb_burst_error_channel;

  localparam int MAX_BURST = 16;
  localparam int N_REC     = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_in = 1'b0;
  logic        data_in_valid = 1'b0;
  logic        inject_en = 1'b0;
  logic [31:0] p_err = 32'd0;
  logic [31:0] p_prop = 32'd0;
  logic        data_out;
  logic        data_out_valid;
  logic        error_flag;
  logic [63:0] total_injected;
  logic [63:0] total_bursts;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [31:0] m_rnd;
  int          m_run;
  logic [63:0] m_injected;
  logic [63:0] m_bursts;
  bit          m_dout;

  // Recorded gapless run used by the replay tests.
  bit          rec_din   [N_REC];
  logic [31:0] rec_perr  [N_REC];
  logic [31:0] rec_pprop [N_REC];
  bit          rec_flip  [N_REC];

  burst_error_channel #(
    .SEED      (32'h0000_0001),
    .MAX_BURST (MAX_BURST),
    .CNT_W     (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .inject_en      (inject_en),
    .p_err          (p_err),
    .p_prop         (p_prop),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .error_flag     (error_flag),
    .total_injected (total_injected),
    .total_bursts   (total_bursts)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // m_run counts flips in the current burst; 0 means no burst in progress.
  task automatic modelReset();
    m_rnd      = 32'h0000_0001;
    m_run      = 0;
    m_injected = '0;
    m_bursts   = '0;
    m_dout     = 1'b0;
  endtask

  task automatic modelStep(input bit v, input bit din, input bit inj,
                           input logic [31:0] pe, input logic [31:0] pp, output bit flip);
    flip = 1'b0;
    if (v) begin
      if (!inj) begin
        m_run = 0;
      end else if (m_run == 0) begin
        if (m_rnd < pe) begin
          flip = 1'b1;
          m_run = 1;
          m_bursts++;
        end
      end else if (m_run < MAX_BURST && m_rnd < pp) begin
        flip = 1'b1;
        m_run++;
      end else begin
        m_run = 0;
      end
      if (flip) m_injected++;
      m_dout = din ^ flip;
      m_rnd  = ref_next(m_rnd);
    end
  endtask

  // Drive one cycle, advance the model, then check everything #1 after the edge.
  task automatic applyStimulus(input bit v, input bit din, input bit inj,
                               input logic [31:0] pe, input logic [31:0] pp, output bit flip);
    data_in_valid = v;
    data_in       = din;
    inject_en     = inj;
    p_err         = pe;
    p_prop        = pp;
    modelStep(v, din, inj, pe, pp, flip);
    @(posedge clk);
    #1;
    checkOutput("valid", 64'(data_out_valid), 64'(v));
    checkOutput("error_flag", 64'(error_flag), 64'(v & flip));
    checkOutput("data_out", 64'(data_out), 64'(m_dout));
    checkOutput("total_injected", total_injected, m_injected);
    checkOutput("total_bursts", total_bursts, m_bursts);
  endtask

  // Reset with a valid bit present to show reset wins and the bit is dropped.
  task automatic doReset();
    rst           = 1'b1;
    data_in_valid = 1'b1;
    data_in       = 1'b1;
    inject_en     = 1'b1;
    p_err         = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    data_in_valid = 1'b0;
    modelReset();
    checkOutput("rst_valid", 64'(data_out_valid), 64'd0);
    checkOutput("rst_error_flag", 64'(error_flag), 64'd0);
    checkOutput("rst_data_out", 64'(data_out), 64'd0);
    checkOutput("rst_injected", total_injected, 64'd0);
    checkOutput("rst_bursts", total_bursts, 64'd0);
  endtask

  initial begin
    bit f;
    bit did_reset;
    modelReset();
    $display("[TB] start");
    doReset();

    // Pass-through: data delayed one cycle, no flips, counters stay zero.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'b1, 32'd0, 32'($urandom), f);
      checkOutput("p0_no_flip", 64'(error_flag), 64'd0);
    end
    checkOutput("p0_injected", total_injected, 64'd0);
    checkOutput("p0_bursts", total_bursts, 64'd0);

    // Always start, never propagate: flips on every other bit.
    doReset();
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'b1, 32'hFFFF_FFFF, 32'd0, f);
      checkOutput("alt_flip", 64'(error_flag), 64'((i % 2) == 0));
    end
    checkOutput("alt_injected", total_injected, 64'd500);
    checkOutput("alt_bursts", total_bursts, 64'd500);

    // Saturated propagation: bursts capped at MAX_BURST, then one clean bit.
    doReset();
    for (int i = 0; i < 170; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, f);
      checkOutput("max_flip", 64'(error_flag), 64'((i % 17) != 16));
    end
    checkOutput("max_injected", total_injected, 64'd160);
    checkOutput("max_bursts", total_bursts, 64'd10);

    // Record a gapless run with random thresholds.
    doReset();
    for (int i = 0; i < N_REC; i++) begin
      rec_din[i]   = 1'($urandom);
      rec_perr[i]  = $urandom_range(32'h1000_0000, 32'h4000_0000);
      rec_pprop[i] = $urandom_range(32'h8000_0000, 32'hF000_0000);
      applyStimulus(1'b1, rec_din[i], 1'b1, rec_perr[i], rec_pprop[i], f);
      rec_flip[i] = f;
    end

    // Same data with valid one cycle in three: identical flip pattern.
    doReset();
    for (int i = 0; i < N_REC; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'b1, 32'($urandom), 32'($urandom), f);
      applyStimulus(1'b0, 1'($urandom), 1'b1, 32'($urandom), 32'($urandom), f);
      applyStimulus(1'b1, rec_din[i], 1'b1, rec_perr[i], rec_pprop[i], f);
      checkOutput("gap_flip", 64'(error_flag), 64'(rec_flip[i]));
    end

    // Reset during the third burst, then replay the stream from the start.
    doReset();
    did_reset = 1'b0;
    for (int i = 0; i < N_REC && !did_reset; i++) begin
      applyStimulus(1'b1, rec_din[i], 1'b1, rec_perr[i], rec_pprop[i], f);
      if (m_bursts == 64'd3 && m_run > 0) begin
        doReset();
        did_reset = 1'b1;
      end
    end
    checkOutput("burst3_reached", 64'(did_reset), 64'd1);
    for (int i = 0; i < N_REC; i++) begin
      applyStimulus(1'b1, rec_din[i], 1'b1, rec_perr[i], rec_pprop[i], f);
      checkOutput("replay_flip", 64'(error_flag), 64'(rec_flip[i]));
    end

    // inject_en dropped for 5 bits mid-burst.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, f);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, f);
      checkOutput("inj_off_flip", 64'(error_flag), 64'd0);
    end
    checkOutput("inj_off_injected", total_injected, 64'd3);
    applyStimulus(1'b1, 1'($urandom), 1'b1, 32'hFFFF_FFFF, 32'd0, f);
    checkOutput("inj_on_new_burst", total_bursts, 64'd2);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                    $urandom_range(32'h0, 32'h8000_0000), 32'($urandom), f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
